// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
// Shared types and helpers for the frequency meter.
//   fm_state_t : measurement FSM state (IDLE, MEASURE)
//   win_last() : terminal value of the gate-window counter for a given
//                code width (window length is 2^(sel_width+1) cycles)
package freq_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } fm_state_t;

  // All-ones value of a (sel_width+1)-bit window counter.
  function automatic int unsigned win_last(input int unsigned sel_width);
    return (32'd1 << (sel_width + 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
// Rising-edge detector for a single-bit signal, with an optional
// two-flop input synchronizer.
// Build option: FREQ_METER_SYNC_EN adds the synchronizer so that an
// asynchronous sig_i is accepted (two extra cycles of latency).
// Ports:
//   clk_i  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sig_i  : signal to watch
//   rise_o : high for the cycle in which a 0->1 transition is seen
module rise_detect (
  input  logic clk_i,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic w_sig;
  logic r_sig_q;

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], sig_i};
    end
  end

  assign w_sig = r_sync[1];
`else
  assign w_sig = sig_i;
`endif

  // History flop runs in every state so the first window cycle already
  // has a valid previous sample.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= w_sig;
    end
  end

  assign rise_o = w_sig & ~r_sig_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
// Counts rising edges of sig_i over a gate window of 2^(SEL_WIDTH+1)
// clock cycles and reports edges-1, i.e. the selection code of the
// phase-accumulator clock generator that produced the signal.
// Build option: FREQ_METER_SYNC_EN (see rise_detect) synchronizes sig_i.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sig_i    : signal under measurement
//   start_i  : start a measurement (honoured in IDLE only)
//   cont_i   : continuous mode, sampled on the last window cycle
//   abort_i  : cancel the measurement in progress, no result
//   meas_o   : measured code (edges-1), held until the next result
//   zero_o   : last window saw no rising edge
//   valid_o  : one-cycle pulse with each new result
//   busy_o   : measurement in progress
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int SEL_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 sig_i,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic                 abort_i,
  output logic [SEL_WIDTH-1:0] meas_o,
  output logic                 zero_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  localparam int unsigned        WIN_LAST_I = win_last(SEL_WIDTH);
  localparam logic [SEL_WIDTH:0] WIN_LAST   = WIN_LAST_I[SEL_WIDTH:0];
  localparam logic [SEL_WIDTH:0] ONE_W      = {{SEL_WIDTH{1'b0}}, 1'b1};
  localparam logic [SEL_WIDTH-1:0] ONE_M    = {{(SEL_WIDTH-1){1'b0}}, 1'b1};

  fm_state_t            r_state;
  fm_state_t            w_state_next;
  logic [SEL_WIDTH:0]   r_win;
  logic [SEL_WIDTH:0]   r_edges;
  logic [SEL_WIDTH:0]   w_total;
  logic                 w_rise;
  logic                 w_last;
  logic                 w_clr;
  logic                 w_load;

  rise_detect u_rise_detect (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .sig_i  (sig_i),
    .rise_o (w_rise)
  );

  assign w_last  = (r_win == WIN_LAST);
  // Includes the rise seen on the current cycle, so the last window cycle
  // contributes to the result it loads.
  assign w_total = r_edges + {{SEL_WIDTH{1'b0}}, w_rise};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = MEASURE;
          w_clr        = 1'b1;
        end
      end
      MEASURE: begin
        // Abort wins over a coinciding window end.
        if (abort_i) begin
          w_state_next = IDLE;
        end else if (w_last) begin
          w_load       = 1'b1;
          w_clr        = 1'b1;
          w_state_next = cont_i ? MEASURE : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_win   <= '0;
      r_edges <= '0;
    end else if (w_clr) begin
      r_win   <= '0;
      r_edges <= '0;
    end else if (r_state == MEASURE) begin
      r_win   <= r_win + ONE_W;
      r_edges <= w_total;
    end
  end

  // For c = 2^SEL_WIDTH the low bits are zero and the subtraction wraps to
  // all-ones, which is exactly c-1 truncated.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      meas_o  <= '0;
      zero_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= w_load;
      if (w_load) begin
        if (w_total == '0) begin
          meas_o <= '0;
          zero_o <= 1'b1;
        end else begin
          meas_o <= w_total[SEL_WIDTH-1:0] - ONE_M;
          zero_o <= 1'b0;
        end
      end
    end
  end

  assign busy_o = (r_state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
// Directed bench for freq_meter (SEL_WIDTH=8, 512-cycle window). sig_i
// comes from a phase-accumulator generator model (9-bit accumulator,
// increment code+1, output = MSB) or from a manual level when halted.
module tb_freq_meter;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_i;
  logic       start_i = 1'b0;
  logic       cont_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] meas_o;
  logic       zero_o;
  logic       valid_o;
  logic       busy_o;

  logic [8:0] acc = 9'd0;
  logic [8:0] inc = 9'd1;
  logic       gen_sig = 1'b0;
  logic       gen_run = 1'b0;
  logic       man_sig = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int vcnt;

  assign sig_i = gen_run ? gen_sig : man_sig;

  always #5 clk_i = ~clk_i;

  freq_meter #(.SEL_WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .sig_i   (sig_i),
    .start_i (start_i),
    .cont_i  (cont_i),
    .abort_i (abort_i),
    .meas_o  (meas_o),
    .zero_o  (zero_o),
    .valid_o (valid_o),
    .busy_o  (busy_o)
  );

  // Generator model, advances away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      acc     = acc + inc;
      gen_sig = acc[8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_code(input logic [7:0] code);
    inc     = {1'b0, code} + 9'd1;
    gen_run = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  // Leaves the bench at the negedge right after the start edge T.
  task automatic start_meas();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Counts negedges until valid_o is seen; -1 if the bound expires.
  task automatic wait_valid(output int k_out);
    k_out = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk_i);
      if (valid_o) begin
        k_out = k;
        break;
      end
    end
  endtask

  task automatic measure(input string tag, input logic [7:0] exp_m, input logic exp_z);
    start_meas();
    chk({tag, ".busy"}, busy_o, 1);
    wait_valid(lat);
    chk({tag, ".lat"}, lat, 512);
    chk({tag, ".meas"}, meas_o, exp_m);
    chk({tag, ".zero"}, zero_o, exp_z);
    chk({tag, ".busy_end"}, busy_o, 0);
    @(negedge clk_i);
    chk({tag, ".valid_1cyc"}, valid_o, 0);
    $display("txn %s: lat=%0d meas=%02h zero=%0b", tag, lat, meas_o, zero_o);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst.meas", meas_o, 0);
    chk("rst.zero", zero_o, 0);
    chk("rst.valid", valid_o, 0);
    chk("rst.busy", busy_o, 0);
    rst_n = 1'b1;

    set_code(8'h3F);
    measure("code3f", 8'h3F, 1'b0);

    // Abort at window cycle 200: result withheld, old value kept.
    start_meas();
    repeat (200) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort.busy", busy_o, 0);
    chk("abort.valid", valid_o, 0);
    chk("abort.meas", meas_o, 8'h3F);
    vcnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (valid_o) vcnt++;
    end
    chk("abort.no_valid", vcnt, 0);
    $display("txn abort: busy=%0b meas=%02h", busy_o, meas_o);

    // Start at window cycle 100 is ignored.
    start_meas();
    repeat (99) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_valid(lat);
    chk("restart.lat", lat + 100, 512);
    chk("restart.meas", meas_o, 8'h3F);
    $display("txn restart_ignored: lat=%0d meas=%02h", lat + 100, meas_o);

    // Start together with abort in IDLE starts a measurement.
    @(negedge clk_i);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("startabort.busy", busy_o, 1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("startabort.abort", busy_o, 0);
    $display("txn start_with_abort: started and cancelled");

    // Continuous mode with the fastest code.
    set_code(8'hFF);
    cont_i = 1'b1;
    start_meas();
    wait_valid(lat);
    chk("cont1.lat", lat, 512);
    chk("cont1.meas", meas_o, 8'hFF);
    chk("cont1.busy", busy_o, 1);
    $display("txn cont1: lat=%0d meas=%02h", lat, meas_o);
    wait_valid(lat);
    chk("cont2.lat", lat, 512);
    chk("cont2.meas", meas_o, 8'hFF);
    cont_i = 1'b0;
    $display("txn cont2: lat=%0d meas=%02h", lat, meas_o);
    wait_valid(lat);
    chk("cont3.lat", lat, 512);
    chk("cont3.meas", meas_o, 8'hFF);
    chk("cont3.busy", busy_o, 0);
    $display("txn cont3: lat=%0d meas=%02h", lat, meas_o);

    // Asynchronous reset mid-window.
    start_meas();
    repeat (300) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    chk("amid.meas", meas_o, 0);
    chk("amid.zero", zero_o, 0);
    chk("amid.valid", valid_o, 0);
    chk("amid.busy", busy_o, 0);
    $display("txn reset_mid: busy=%0b meas=%02h", busy_o, meas_o);
    @(negedge clk_i);
    rst_n = 1'b1;

    set_code(8'h80);
    measure("code80", 8'h80, 1'b0);
    set_code(8'h10);
    measure("code10", 8'h10, 1'b0);
    set_code(8'h00);
    measure("code00", 8'h00, 1'b0);

    gen_run = 1'b0;
    man_sig = 1'b0;
    repeat (4) @(negedge clk_i);
    measure("halted", 8'h00, 1'b1);

    // Single rise arriving for the last window edge: counted only without
    // the synchronizer's extra two cycles.
    start_meas();
    repeat (511) @(negedge clk_i);
    man_sig = 1'b1;
    wait_valid(lat);
    chk("late.lat", lat, 1);
    chk("late.meas", meas_o, 0);
`ifdef FREQ_METER_SYNC_EN
    chk("late.zero", zero_o, 1);
`else
    chk("late.zero", zero_o, 0);
`endif
    $display("txn late_rise: meas=%02h zero=%0b", meas_o, zero_o);
    man_sig = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
